ram_pair_rmw_engine: RTL and testbench

Parametrised read-modify-write engine that sweeps a programmable address range across a pair of external single-port synchronous RAMs. At each address it reads one word from each RAM, combines the two words in one of four arithmetic modes, and writes the two results back to the same address. It sits between a control source (start, range, mode) and two single-port RAM instances with a shared address bus. It is the generalised successor to the fixed 8-bit, 512-word, sum/difference sweeper.

---
 rtl/ram_pair_rmw_engine_pkg.sv | 18 +
 rtl/ram_pair_rmw_engine_if.sv | 25 ++
 rtl/ram_pair_rmw_engine_alu.sv | 54 +++++
 rtl/ram_pair_rmw_engine.sv | 113 +++++++++++
 tb/tb_ram_pair_rmw_engine.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pair_rmw_engine_pkg.sv
// Shared types for the RAM-pair read-modify-write engine.
// Mode and FSM state encodings.
package ram_pair_rmw_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_HALF = 2'd1,
    MODE_SAT  = 2'd2,
    MODE_SWAP = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_pair_rmw_engine_if.sv
// Shared-address bus to a pair of single-port RAMs.
// master = engine, slave = the two RAMs.
interface ram_pair_rmw_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] address;
  logic [1:0]        wren;
  logic [DATA_W-1:0] write_data0;
  logic [DATA_W-1:0] write_data1;
  logic [DATA_W-1:0] read_data0;
  logic [DATA_W-1:0] read_data1;

  modport master (
    output address, wren,
    output write_data0, write_data1,
    input  read_data0, read_data1
  );

  modport slave (
    input  address, wren,
    input  write_data0, write_data1,
    output read_data0, read_data1
  );
endinterface

// File: rtl/ram_pair_rmw_engine_alu.sv
// Combinational word combiner for one address.
// ovf_evt flags a wrap (ADD) or a clip (SAT).
module rmw_alu
  import ram_pair_rmw_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  mode_e             mode,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic              ovf_evt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  logic            carry;
  logic            borrow;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif    = {1'b0, a} - {1'b0, b};
  assign carry  = sum[DATA_W];
  assign borrow = dif[DATA_W];

  // Per-mode result selection; dif is the signed
  // DATA_W+1 difference, so dif[DATA_W:1] is the
  // arithmetic half truncated to DATA_W.
  always_comb begin
    w0      = sum[DATA_W-1:0];
    w1      = dif[DATA_W-1:0];
    ovf_evt = 1'b0;
    unique case (mode)
      MODE_ADD: begin
        ovf_evt = carry | borrow;
      end
      MODE_HALF: begin
        w0 = sum[DATA_W:1];
        w1 = dif[DATA_W:1];
      end
      MODE_SAT: begin
        w0      = carry ? '1 : sum[DATA_W-1:0];
        w1      = borrow ? '0 : dif[DATA_W-1:0];
        ovf_evt = carry | borrow;
      end
      MODE_SWAP: begin
        w0 = b;
        w1 = a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_pair_rmw_engine.sv
// Sweeps an address range over two RAMs, reading,
// combining and writing back one word pair per address.
module ram_pair_rmw_engine
  import ram_pair_rmw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [1:0]        mode,
  ram_pair_rmw_engine_if.master ram,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W:0]   count
);

  state_e            state;
  state_e            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] end_q;
  mode_e             mode_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [ADDR_W:0]   cnt_q;
  logic              last;
  logic              alu_ovf;

  assign last = (addr_q == end_q);

  rmw_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a       (ram.read_data0),
    .b       (ram.read_data1),
    .mode    (mode_q),
    .w0      (ram.write_data0),
    .w1      (ram.write_data1),
    .ovf_evt (alu_ovf)
  );

  // State register.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state and write enable; wren follows state
  // so an async reset drops it at once.
  always_comb begin
    state_n  = state;
    ram.wren = 2'b00;
    unique case (state)
      S_IDLE:  if (start) state_n = S_READ;
      S_READ:  state_n = S_WRITE;
      S_WRITE: begin
        ram.wren = 2'b11;
        state_n  = last ? S_IDLE : S_READ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Range/mode latches, address, count and flags.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      end_q  <= '0;
      mode_q <= MODE_ADD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= start_addr;
            end_q  <= end_addr;
            mode_q <= mode_e'(mode);
            busy_q <= 1'b1;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + (ADDR_W+1)'(1);
          ovf_q <= ovf_q | alu_ovf;
          if (last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram.address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign count       = cnt_q;

endmodule

// File: tb/tb_ram_pair_rmw_engine.sv
// Bench for ram_pair_rmw_engine with two 1-cycle RAMs
// and an array-level reference of each run.
module tb_ram_pair_rmw_engine;
  import ram_pair_rmw_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic [AW-1:0] sa_i   = '0;
  logic [AW-1:0] ea_i   = '0;
  logic [1:0]    md_i   = '0;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [AW:0]   count;

  ram_pair_rmw_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_pair_rmw_engine #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (sa_i),
    .end_addr   (ea_i),
    .mode       (md_i),
    .ram        (bus.master),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .count      (count)
  );

  always #10 clk = ~clk;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;
  int            exp0 [DEPTH];
  int            exp1 [DEPTH];
  bit            load_req = 1'b0;

  // Two single-port RAMs, 1-cycle read, plus bulk preload.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] <= DW'(exp0[i]);
        mem1[i] <= DW'(exp1[i]);
      end
    end else begin
      if (bus.wren[0]) mem0[bus.address] <= bus.write_data0;
      if (bus.wren[1]) mem1[bus.address] <= bus.write_data1;
    end
    q0 <= mem0[bus.address];
    q1 <= mem1[bus.address];
  end

  assign bus.read_data0 = q0;
  assign bus.read_data1 = q1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, req);
  endtask

  // Word-pair rule straight from the mode definitions.
  function automatic void ref_op(input int md, input int a,
                                 input int b, output int w0,
                                 output int w1, output bit o);
    int s;
    int d;
    s  = a + b;
    d  = a - b;
    w0 = 0;
    w1 = 0;
    o  = 0;
    case (md)
      0: begin
        w0 = s % 256;
        w1 = (d + 256) % 256;
        o  = (s > 255) || (d < 0);
      end
      1: begin
        w0 = s / 2;
        w1 = (d >>> 1) & 255;
      end
      2: begin
        w0 = (s > 255) ? 255 : s;
        w1 = (d < 0) ? 0 : d;
        o  = (s > 255) || (d < 0);
      end
      default: begin
        w0 = b;
        w1 = a;
      end
    endcase
  endfunction

  // Apply a whole run to the expected memories.
  task automatic model_run(input int sa, input int ea, input int md,
                           output int n, output bit o);
    int a;
    int w0;
    int w1;
    bit ov;
    a = sa;
    n = 0;
    o = 0;
    for (int k = 0; k < DEPTH; k++) begin
      ref_op(md, exp0[a], exp1[a], w0, w1, ov);
      exp0[a] = w0;
      exp1[a] = w1;
      o = o | ov;
      n++;
      if (a == ea) break;
      a = (a + 1) % DEPTH;
    end
  endtask

  function automatic int mem_diff();
    int m;
    m = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem0[i] !== DW'(exp0[i]) || mem1[i] !== DW'(exp1[i]))
        m++;
    return m;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < DEPTH; i++) begin
      exp0[i] = int'($urandom_range(0, 255));
      exp1[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic load();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic go_now(input int sa, input int ea, input int md);
    start = 1'b1;
    sa_i  = AW'(sa);
    ea_i  = AW'(ea);
    md_i  = 2'(md);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic go(input int sa, input int ea, input int md);
    @(negedge clk);
    go_now(sa, ea, md);
  endtask

  // Count edges after the start edge until done appears.
  task automatic wait_done(input int n, input int c0,
                           input string nm);
    int c;
    c = c0;
    while (!done && c < 2 * n + 20) begin
      @(posedge clk);
      #1 c++;
    end
    chk(nm, c, 2 * n);
  endtask

  typedef struct {
    int md;
    int addr;
    int a;
    int b;
    int w0;
    int w1;
    int ov;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int   n;
    bit   o;
    int   sa;
    int   ea;
    int   md;

    tbl[0] = '{0,  5, 200, 100,  44, 100, 1};
    tbl[1] = '{1, 40,   7,  10,   8, 254, 0};
    tbl[2] = '{1, 41, 255, 255, 255,   0, 0};
    tbl[3] = '{2, 42, 250,  10, 255, 240, 1};
    tbl[4] = '{2, 43,   5,   9,  14,   0, 1};
    tbl[5] = '{3, 44,  12,  34,  34,  12, 0};

    #35;
    chk("rst_address", int'(bus.address), 0);
    chk("rst_wren", int'(bus.wren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[k]) begin
      fill_rand();
      exp0[tbl[k].addr] = tbl[k].a;
      exp1[tbl[k].addr] = tbl[k].b;
      load();
      go(tbl[k].addr, tbl[k].addr, tbl[k].md);
      model_run(tbl[k].addr, tbl[k].addr, tbl[k].md, n, o);
      wait_done(n, 0, "tbl_latency");
      chk("tbl_w0", int'(mem0[tbl[k].addr]), tbl[k].w0);
      chk("tbl_w1", int'(mem1[tbl[k].addr]), tbl[k].w1);
      chk("tbl_ovf", int'(ovf), tbl[k].ov);
      chk("tbl_count", int'(count), 1);
      chk("tbl_mem", mem_diff(), 0);
    end

    for (int r = 0; r < 10; r++) begin
      fill_rand();
      load();
      sa = int'($urandom_range(0, DEPTH - 1));
      ea = (sa + int'($urandom_range(0, 15))) % DEPTH;
      md = int'($urandom_range(0, 3));
      go(sa, ea, md);
      chk("rnd_busy", int'(busy), 1);
      model_run(sa, ea, md, n, o);
      wait_done(n, 0, "rnd_latency");
      chk("rnd_count", int'(count), n);
      chk("rnd_ovf", int'(ovf), int'(o));
      chk("rnd_mem", mem_diff(), 0);
      @(posedge clk);
      #1 chk("rnd_done_pulse", int'(done), 0);
    end

    for (int i = 0; i < DEPTH; i++) begin
      exp0[i] = 3;
      exp1[i] = 1;
    end
    load();
    go(0, 511, int'(MODE_ADD));
    model_run(0, 511, int'(MODE_ADD), n, o);
    wait_done(512, 0, "sweep_busy_cycles");
    chk("sweep_count", int'(count), 512);
    chk("sweep_ovf", int'(ovf), 0);
    chk("sweep_mem", mem_diff(), 0);

    fill_rand();
    load();
    go(510, 1, int'(MODE_SWAP));
    model_run(510, 1, int'(MODE_SWAP), n, o);
    repeat (3) @(negedge clk);
    start = 1'b1;
    sa_i  = AW'(100);
    ea_i  = AW'(100);
    md_i  = 2'(MODE_ADD);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, 3, "swap_latency");
    chk("swap_count", int'(count), 4);
    chk("swap_mem", mem_diff(), 0);
    go_now(20, 22, int'(MODE_HALF));
    model_run(20, 22, int'(MODE_HALF), n, o);
    chk("b2b_busy", int'(busy), 1);
    wait_done(n, 0, "b2b_latency");
    chk("b2b_count", int'(count), 3);
    chk("b2b_mem", mem_diff(), 0);

    fill_rand();
    load();
    go(0, 7, int'(MODE_ADD));
    repeat (7) @(posedge clk);
    #1;
    chk("mid_address", int'(bus.address), 3);
    chk("mid_wren", int'(bus.wren), 3);
    #4 resetn = 1'b0;
    #1;
    chk("arst_wren", int'(bus.wren), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(count), 0);
    @(negedge clk);
    resetn = 1'b1;
    fill_rand();
    load();
    go(0, 7, int'(MODE_ADD));
    model_run(0, 7, int'(MODE_ADD), n, o);
    wait_done(n, 0, "post_rst_latency");
    chk("post_rst_count", int'(count), 8);
    chk("post_rst_ovf", int'(ovf), int'(o));
    chk("post_rst_mem", mem_diff(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
